axi_ace_master_ctrl: RTL
========================

AXI_ACE_MASTER_CTRL -- requirements
Module: axi_ace_master_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, meaning the address width of all address channels.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the data width of write data, read data and command data.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the watchdog limit in cycles (used only when the timeout feature is compiled in).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted
- cmd_op  in  2  00 write, 01 read, 10 snoop, 11 illegal
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  completion available
- rsp_ready  in  1  completion consumed
- rsp_rdata  out  DATA_W  read data; 0 for non-read ops
- rsp_err  out  1  illegal op or timeout
- awvalid/awready, awaddr  out/in, out  1/1, ADDR_W  AXI write address
- wvalid/wready, wdata  out/in, out  1/1, DATA_W  AXI write data
- bvalid/bready  in/out  1/1  AXI write response
- arvalid/arready, araddr  out/in, out  1/1, ADDR_W  AXI read address
- rvalid/rready, rdata  in/out, in  1/1, DATA_W  AXI read data
- acvalid/acready, acaddr  out/in, out  1/1, ADDR_W  ACE snoop address
- crvalid/crready  in/out  1/1  ACE snoop response

Function
REQ-005 The FSM SHALL have states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, SN_REQ, SN_RESP, DONE.
REQ-006 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&&cmd_ready, op/addr/wdata SHALL be registered, and the next state SHALL be WR_REQ/RD_REQ/SN_REQ by op, or DONE with rsp_err=1 for op 11 (no bus activity).
REQ-007 In WR_REQ, awvalid and wvalid SHALL rise together on the cycle after acceptance, and each SHALL drop independently after its own handshake edge; the FSM SHALL enter WR_RESP once both handshakes have occurred, including when they occur in the same cycle.
REQ-008 In WR_RESP, bready SHALL be 1; bvalid&&bready SHALL move the FSM to DONE.
REQ-009 In RD_REQ, arvalid SHALL be 1 until arvalid&&arready; in RD_DATA, rready SHALL be 1, and rvalid&&rready SHALL capture rdata into rsp_rdata and move the FSM to DONE.
REQ-010 In SN_REQ, acvalid SHALL be 1 until acvalid&&acready; in SN_RESP, crready SHALL be 1, and crvalid&&crready SHALL move the FSM to DONE.
REQ-011 Once asserted, no valid SHALL deassert before its handshake, and awaddr/wdata/araddr/acaddr SHALL stay stable while the corresponding valid is high.
REQ-012 In DONE, rsp_valid SHALL be 1 and rsp_rdata/rsp_err SHALL be held until rsp_ready; rsp_valid&&rsp_ready SHALL return the FSM to IDLE.
REQ-013 Minimum latency with all readies high SHALL be 4 cycles from command accept to rsp_valid (accept, req, resp, done).
REQ-014 rsp_rdata SHALL be 0 for write, snoop and illegal ops.

Reset
REQ-015 While rst_n=0, the FSM SHALL be IDLE and every output SHALL be 0 except cmd_ready, which SHALL be 1 after reset release.
REQ-016 Reset asserted mid-transaction SHALL immediately drop all valids and readies, discard the command, and produce no response.

Configuration
REQ-017 With macro AXI_ACE_MASTER_TIMEOUT_EN defined, a counter SHALL clear on entry to each REQ/RESP/DATA state and increment every cycle spent there.
REQ-018 With AXI_ACE_MASTER_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES, the block SHALL drop all bus valids/readies and enter DONE with rsp_err=1.
REQ-019 Without AXI_ACE_MASTER_TIMEOUT_EN, the block SHALL wait indefinitely, and rsp_err SHALL be set only by illegal op.

Verification
REQ-020 Write op, addr 5, data DEADBEEF, responder readies high -> single AW/W handshake with awaddr=5 and wdata=DEADBEEF, then rsp_valid with rsp_err=0 and rsp_rdata=0.
REQ-021 Read op, addr 5, against a memory model holding DEADBEEF -> araddr=5, then rsp_rdata=DEADBEEF and rsp_err=0.
REQ-022 awready delayed 3 cycles while wready is immediate -> wvalid drops after 1 cycle, awvalid stays high 4 cycles with awaddr stable, and bready rises only after both handshakes.
REQ-023 Snoop op, addr 5, then crvalid 2 cycles after acready -> acaddr=5 with one handshake, crready high until crvalid, then rsp_err=0.
REQ-024 Illegal op 11 -> no bus valid ever asserted and rsp_err=1; with the macro defined and TIMEOUT_CYCLES=8, a read with arready tied 0 -> rsp_err=1 after 8 cycles.
REQ-025 rst_n pulsed low during RD_DATA -> all outputs 0, no rsp_valid, and the next command completes normally.

Source files
------------

// File: rtl/axi_ace_master_ctrl.sv
// Single-outstanding command sequencer driving AXI write/read and ACE snoop channels.
// Optional watchdog: define AXI_ACE_MASTER_TIMEOUT_EN to abort stalled bus phases.
module axi_ace_master_ctrl #(
  parameter int ADDR_W         = 6,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              wvalid,
  input  logic              wready,
  output logic [DATA_W-1:0] wdata,
  input  logic              bvalid,
  output logic              bready,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  output logic              acvalid,
  input  logic              acready,
  output logic [ADDR_W-1:0] acaddr,
  input  logic              crvalid,
  output logic              crready
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_SN_REQ  = 3'd5;
  localparam logic [2:0] S_SN_RESP = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  localparam logic [1:0] OP_WR = 2'b00;
  localparam logic [1:0] OP_RD = 2'b01;
  localparam logic [1:0] OP_SN = 2'b10;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              aw_pend_q, aw_pend_d;
  logic              w_pend_q, w_pend_d;
  logic              err_q, err_d;
  logic              timeout;

`ifdef AXI_ACE_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_st;

  assign wait_st = (state_q != S_IDLE) && (state_q != S_DONE);
  // The counter reads 0 on the first cycle in a state, so TIMEOUT_CYCLES-1 is the last cycle allowed.
  assign timeout = wait_st && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (wait_st && (state_d == state_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
`endif

  always_comb begin
    // NOTE: every _d takes its hold value first, so no path through the case can infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          case (cmd_op)
            OP_WR: begin
              state_d   = S_WR_REQ;
              aw_pend_d = 1'b1;
              w_pend_d  = 1'b1;
            end
            OP_RD:   state_d = S_RD_REQ;
            OP_SN:   state_d = S_SN_REQ;
            default: begin
              state_d = S_DONE;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      S_WR_REQ: begin
        // AW and W retire independently; leave only once both have handshaken.
        if (awready) aw_pend_d = 1'b0;
        if (wready)  w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d) state_d = S_WR_RESP;
      end
      S_WR_RESP: if (bvalid)  state_d = S_DONE;
      S_RD_REQ:  if (arready) state_d = S_RD_DATA;
      S_RD_DATA: begin
        if (rvalid) begin
          rdata_d = rdata;
          state_d = S_DONE;
        end
      end
      S_SN_REQ:  if (acready)   state_d = S_SN_RESP;
      S_SN_RESP: if (crvalid)   state_d = S_DONE;
      S_DONE:    if (rsp_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (timeout && (state_d == state_q)) begin
      state_d   = S_DONE;
      err_d     = 1'b1;
      aw_pend_d = 1'b0;
      w_pend_d  = 1'b0;
    end
  end

  // NOTE: all state uses non-blocking assignments, and every flop is cleared by the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
    end
  end

  // cmd_ready is gated by rst_n so every output reads 0 while reset is held.
  assign cmd_ready = rst_n && (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign awvalid = aw_pend_q;
  assign awaddr  = addr_q;
  assign wvalid  = w_pend_q;
  assign wdata   = wdata_q;
  assign bready  = (state_q == S_WR_RESP);
  assign arvalid = (state_q == S_RD_REQ);
  assign araddr  = addr_q;
  assign rready  = (state_q == S_RD_DATA);
  assign acvalid = (state_q == S_SN_REQ);
  assign acaddr  = addr_q;
  assign crready = (state_q == S_SN_RESP);

endmodule
